pixel_write_scheduler: RTL

- Sequences the write side of the VGA pixel buffer RAM.
- Arbitrates the single RAM write port between two sources: a frame-clear fill and the fractal engine.
- Scans pixel coordinates in raster order, handshakes each pixel with the fractal engine, then writes the saturated escape value.
- Sits between the top-level draw/clear controls, the fractal engine and the pixel buffer write port. Runs entirely in the clk domain.

---
 rtl/pixel_write_scheduler_pkg.sv | 34 +++
 rtl/pixel_write_scheduler_if.sv | 37 +++
 rtl/pixel_write_scheduler_raster_counter.sv | 62 ++++++
 rtl/pixel_write_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// pxl_sched_pkg
// Shared definitions for the pixel write scheduler: the scheduler state
// encoding, default geometry/width constants and the escape saturation helper.
// No ports (package).
// ----------------------------------------------------------------------------
package pxl_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        REQ,
        WAIT,
        WRITE
    } sched_state_t;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 4;

    // Clamp a 16-bit iteration count to the largest value representable in
    // 'width' bits. The caller narrows the result to its stored width.
    function automatic logic [15:0] sat_escape(input logic [15:0] value,
                                               input int unsigned width);
        logic [16:0] limit;
        limit = 17'(1) << width;
        if ({1'b0, value} < limit)
            return value;
        else
            return 16'(limit - 17'd1);
    endfunction

endpackage

// File: rtl/pixel_write_scheduler_if.sv
// ----------------------------------------------------------------------------
// pixel_write_scheduler_if
// Bundles the fractal engine handshake and the pixel RAM write port.
//   eng_ready   engine idle, may accept a pixel          (engine -> scheduler)
//   eng_done    one-cycle result strobe                  (engine -> scheduler)
//   eng_escape  16-bit iteration count, valid with done  (engine -> scheduler)
//   eng_start   one-cycle pixel launch                   (scheduler -> engine)
//   eng_x/y     current pixel coordinates                (scheduler -> engine)
//   wr_en/addr/data  RAM write port                      (scheduler -> RAM)
// modport master: scheduler side; modport slave: engine/RAM side.
// ----------------------------------------------------------------------------
interface pixel_write_scheduler_if
    import pxl_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              eng_ready;
    logic              eng_done;
    logic [15:0]       eng_escape;
    logic              eng_start;
    logic [9:0]        eng_x;
    logic [9:0]        eng_y;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  eng_ready, eng_done, eng_escape,
        output eng_start, eng_x, eng_y, wr_en, wr_addr, wr_data
    );

    modport slave (
        output eng_ready, eng_done, eng_escape,
        input  eng_start, eng_x, eng_y, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pixel_write_scheduler_raster_counter.sv
// ----------------------------------------------------------------------------
// raster_counter
// Holds the current pixel x/y and the registered RAM address y*H_RES+x.
//   clk, reset   clock, synchronous active-low reset
//   clear_xy     return to pixel (0,0) (wins over advance)
//   advance      step to the next pixel in raster order, wrapping at frame end
//   x, y         current coordinates
//   last_pixel   current pixel is (H_RES-1, V_RES-1)
//   addr         registered linear address of (x, y)
// ----------------------------------------------------------------------------
module raster_counter
    import pxl_sched_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_xy,
    input  logic              advance,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic              last_pixel,
    output logic [ADDR_W-1:0] addr
);
    logic [9:0] x_next;
    logic [9:0] y_next;

    assign last_pixel = (x == 10'(H_RES - 1)) && (y == 10'(V_RES - 1));

    always_comb begin
        x_next = x;
        y_next = y;
        if (clear_xy) begin
            x_next = '0;
            y_next = '0;
        end else if (advance) begin
            if (x == 10'(H_RES - 1)) begin
                x_next = '0;
                y_next = (y == 10'(V_RES - 1)) ? 10'd0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // The address is computed from the next coordinates so it is already
    // registered and aligned with x/y in the cycle they are used.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else begin
            x    <= x_next;
            y    <= y_next;
            addr <= ADDR_W'(y_next) * ADDR_W'(H_RES) + ADDR_W'(x_next);
        end
    end

endmodule

// File: rtl/pixel_write_scheduler.sv
// ----------------------------------------------------------------------------
// pixel_write_scheduler
// Owns the pixel RAM write port. Either fills the RAM with zero (clear) or
// walks the frame in raster order, launching each pixel on the fractal engine
// and writing its saturated escape value.
//   clk, reset    clock, synchronous active-low reset
//   start_frame   one-cycle request to compute a frame (held pending if busy)
//   clear_req     one-cycle request to zero-fill the RAM (wins over start)
//   bus           pixel_write_scheduler_if.master: engine handshake + RAM port
//   busy          scheduler not in IDLE
//   frame_done    one-cycle pulse after the last frame write
//   clear_done    one-cycle pulse after the last clear write
//   timeout_err   one-cycle pulse when a pixel is written after an engine
//                 watchdog expiry (only with PXL_SCHED_TIMEOUT_EN)
// Optional feature macro: PXL_SCHED_TIMEOUT_EN enables the engine watchdog
// (parameter TIMEOUT and port timeout_err).
// ----------------------------------------------------------------------------
module pixel_write_scheduler
    import pxl_sched_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef PXL_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT = 4096
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic start_frame,
    input  logic clear_req,
    pixel_write_scheduler_if.master bus,
    output logic busy,
    output logic frame_done,
    output logic clear_done
`ifdef PXL_SCHED_TIMEOUT_EN
    , output logic timeout_err
`endif
);
    sched_state_t      state;
    sched_state_t      state_next;
    logic              start_pend;
    logic              clear_pend;
    logic              start_any;
    logic              clear_any;
    logic              go_clear;
    logic              take_start;
    logic              clear_xy;
    logic              advance;
    logic              last_pixel;
    logic              timeout_hit;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] esc_q;

    raster_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .clear_xy   (clear_xy),
        .advance    (advance),
        .x          (x),
        .y          (y),
        .last_pixel (last_pixel),
        .addr       (addr)
    );

    // A request arriving in the same cycle it is acted on counts as pending.
    assign start_any = start_pend | start_frame;
    assign clear_any = clear_pend | clear_req;

`ifdef PXL_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Fires on the TIMEOUT-th consecutive WAIT cycle without a result.
    assign timeout_hit = (state == WAIT) && !bus.eng_done &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt    <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            timeout_err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear_xy   = 1'b0;
        advance    = 1'b0;
        go_clear   = 1'b0;
        take_start = 1'b0;
        case (state)
            IDLE: begin
                if (clear_any) begin
                    state_next = CLEAR;
                    clear_xy   = 1'b1;
                    go_clear   = 1'b1;
                end else if (start_any) begin
                    state_next = REQ;
                    clear_xy   = 1'b1;
                    take_start = 1'b1;
                end
            end
            CLEAR: begin
                advance = 1'b1;
                if (last_pixel)
                    state_next = IDLE;
            end
            REQ: begin
                if (bus.eng_ready)
                    state_next = WAIT;
            end
            WAIT: begin
                if (bus.eng_done || timeout_hit)
                    state_next = WRITE;
            end
            WRITE: begin
                advance = 1'b1;
                // A completed frame ends normally even if a clear is pending;
                // IDLE then picks the clear up.
                if (last_pixel) begin
                    state_next = IDLE;
                end else if (clear_any) begin
                    state_next = CLEAR;
                    clear_xy   = 1'b1;
                    go_clear   = 1'b1;
                end else begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        bus.eng_start = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        case (state)
            CLEAR: bus.wr_en = 1'b1;
            REQ:   bus.eng_start = bus.eng_ready;
            WRITE: begin
                bus.wr_en   = 1'b1;
                bus.wr_data = esc_q;
            end
            default: ;
        endcase
    end

    assign bus.eng_x   = x;
    assign bus.eng_y   = y;
    assign bus.wr_addr = addr;

    // Pending requests; a clear arriving while already clearing is absorbed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_pend <= 1'b0;
            clear_pend <= 1'b0;
        end else begin
            if (take_start)
                start_pend <= 1'b0;
            else if (start_frame)
                start_pend <= 1'b1;
            if (go_clear)
                clear_pend <= 1'b0;
            else if (clear_req && state != CLEAR)
                clear_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            esc_q      <= '0;
            frame_done <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            if (state == WAIT && bus.eng_done)
                esc_q <= DATA_W'(sat_escape(bus.eng_escape, DATA_W));
            else if (timeout_hit)
                esc_q <= '1;
            frame_done <= (state == WRITE) && last_pixel;
            clear_done <= (state == CLEAR) && last_pixel;
        end
    end

endmodule
